// File: rtl/ula_mc_pkg.sv
// Shared opcode, FSM state and sizing definitions for the multi-cycle ALU.
package ula_mc_pkg;

    typedef enum logic [2:0] {
        ULA_ADD = 3'd0,
        ULA_SUB = 3'd1,
        ULA_SLL = 3'd2,
        ULA_SRL = 3'd3,
        ULA_SLT = 3'd4,
        ULA_MUL = 3'd5,
        ULA_SRA = 3'd6,
        ULA_RSV = 3'd7
    } ula_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } ula_state_e;

    localparam int ULA_WIDTH_MIN = 4;
    localparam int ULA_WIDTH_MAX = 32;

    // Counter must reach WIDTH itself, hence one bit beyond clog2.
    function automatic int iter_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/ula_mul_iter.sv
// Radix-2 shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
module ula_mul_iter
    import ula_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int CW = iter_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH:0]   sum;

    // The multiplier shifts out of lo_q as product bits shift in from the top.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        sum  = '0;
        acc_d = acc_q;
        lo_d  = lo_q;
        sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        acc_d = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
    end

    assign done    = busy_q && (cnt_q == LAST_ITER);
    assign prod_lo = lo_d;
    assign prod_hi = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            acc_q   <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            acc_q   <= '0;
            lo_q    <= mplier_in;
            mcand_q <= mcand_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ALU: single-cycle ops finish at accept, MUL runs the iterative multiplier.
module ula_mc
    import ula_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [2:0]       ctrl_ula,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] SHAMT_LIM = WIDTH'(WIDTH);

    ula_state_e       state_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q, ovf_q, out_valid_q, in_ready_q;

    ula_op_e          op_d;
    logic [WIDTH-1:0] alu_out_d;
    logic             alu_carry_d, alu_ovf_d;
    logic [WIDTH:0]   add_w, sub_w;
    logic             shamt_big;
    logic             accept, mul_start, mul_done;
    logic [WIDTH-1:0] mul_lo, mul_hi;

    assign op_d      = ula_op_e'(ctrl_ula);
    assign accept    = in_valid && in_ready_q;
    assign mul_start = accept && (op_d == ULA_MUL);

    assign add_w     = {1'b0, inA} + {1'b0, inB};
    assign sub_w     = {1'b0, inA} - {1'b0, inB};
    assign shamt_big = (inB >= SHAMT_LIM);

    always_comb begin
        alu_out_d   = '0;
        alu_carry_d = 1'b0;
        alu_ovf_d   = 1'b0;
        case (op_d)
            ULA_ADD: begin
                alu_out_d   = add_w[WIDTH-1:0];
                alu_carry_d = add_w[WIDTH];
                alu_ovf_d   = (inA[WIDTH-1] == inB[WIDTH-1]) && (add_w[WIDTH-1] != inA[WIDTH-1]);
            end
            ULA_SUB: begin
                alu_out_d   = sub_w[WIDTH-1:0];
                alu_carry_d = sub_w[WIDTH];
                alu_ovf_d   = (inA[WIDTH-1] != inB[WIDTH-1]) && (sub_w[WIDTH-1] != inA[WIDTH-1]);
            end
            ULA_SLL: alu_out_d = shamt_big ? '0 : (inA << inB);
            ULA_SRL: alu_out_d = shamt_big ? '0 : (inA >> inB);
            ULA_SRA: alu_out_d = shamt_big ? {WIDTH{inA[WIDTH-1]}}
                                           : $unsigned($signed(inA) >>> inB);
            ULA_SLT: alu_out_d = {{(WIDTH-1){1'b0}}, (inA < inB)};
            // MUL result comes from the multiplier; reserved opcode yields zero.
            default: ;
        endcase
    end

    ula_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start),
        .mcand_in  (inA),
        .mplier_in (inB),
        .done      (mul_done),
        .prod_lo   (mul_lo),
        .prod_hi   (mul_hi)
    );

    // Result and flags only load on entry to DONE, so they hold through IDLE and MUL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (op_d == ULA_MUL) begin
                            state_q <= ST_MUL;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_q       <= alu_out_d;
                            carry_q     <= alu_carry_d;
                            ovf_q       <= alu_ovf_d;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        out_q       <= mul_lo;
                        carry_q     <= |mul_hi;
                        ovf_q       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = (out_q == '0);

endmodule

// File: tb/tb_ula_mc.sv
// Bench for ula_mc: arithmetic reference model with per-cycle compare plus directed literal vectors.
module tb_ula_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] inA, inB, out;
    logic [2:0] ctrl_ula;
    logic       zero, carry, ovf;

    logic        v16_in_valid, v16_in_ready, v16_out_valid, v16_out_ready;
    logic [15:0] v16_a, v16_b, v16_out;
    logic [2:0]  v16_op;
    logic        v16_zero, v16_carry, v16_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ula_mc #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inA(inA), .inB(inB), .ctrl_ula(ctrl_ula), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .zero(zero), .carry(carry), .ovf(ovf)
    );

    ula_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16_in_valid), .in_ready(v16_in_ready),
        .inA(v16_a), .inB(v16_b), .ctrl_ula(v16_op), .out_valid(v16_out_valid),
        .out_ready(v16_out_ready), .out(v16_out), .zero(v16_zero), .carry(v16_carry), .ovf(v16_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        o;
    } res_t;

    function automatic res_t ref_op(input int op, input longint a, input longint b, input int w);
        res_t   res;
        longint mask, sa, sb, s, smax, smin;
        mask = (longint'(1) << w) - 1;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sa = (a > smax) ? a - (longint'(1) << w) : a;
        sb = (b > smax) ? b - (longint'(1) << w) : b;
        res = '0;
        case (op)
            0: begin
                s = a + b;
                res.r = 32'(s & mask);
                res.c = (s > mask);
                res.o = (sa + sb > smax) || (sa + sb < smin);
            end
            1: begin
                res.r = 32'((a - b) & mask);
                res.c = (a < b);
                res.o = (sa - sb > smax) || (sa - sb < smin);
            end
            2: res.r = (b >= w) ? 32'd0 : 32'((a << b) & mask);
            3: res.r = (b >= w) ? 32'd0 : 32'(a >> b);
            4: res.r = (a < b) ? 32'd1 : 32'd0;
            5: begin
                s = a * b;
                res.r = 32'(s & mask);
                res.c = ((s >> w) != 0);
            end
            6: res.r = (b >= w) ? ((sa < 0) ? 32'(mask) : 32'd0) : 32'((sa >>> b) & mask);
            default: res.r = 32'd0;
        endcase
        return res;
    endfunction

    // Model: result appears at the accept edge (MUL: WIDTH edges later) and stays until taken.
    logic m_valid;
    int   m_pend;
    res_t m_res, p_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pend  <= 0;
            m_res   <= '0;
            p_res   <= '0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_pend > 0) begin
            if (m_pend == 1) begin
                m_valid <= 1'b1;
                m_res   <= p_res;
            end
            m_pend <= m_pend - 1;
        end else if (in_valid) begin
            if (ctrl_ula == 3'd5) begin
                m_pend <= 8;
                p_res  <= ref_op(5, longint'(inA), longint'(inB), 8);
            end else begin
                m_valid <= 1'b1;
                m_res   <= ref_op(int'(ctrl_ula), longint'(inA), longint'(inB), 8);
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_in_ready", in_ready, !m_valid && (m_pend == 0));
        check("cmp_out_valid", out_valid, m_valid);
        check("cmp_out", out, m_res.r[7:0]);
        check("cmp_zero", zero, m_res.r[7:0] == 8'h00);
        check("cmp_carry", carry, m_res.c);
        check("cmp_ovf", ovf, m_res.o);
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b, r;
        bit         c, o;
        int         edges;
        int         hold;
    } vec_t;

    vec_t vecs[15];

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) check("issue_timeout", 1, 0);
        ctrl_ula = op;
        inA      = a;
        inB      = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        inA      = 8'($urandom);
        inB      = 8'($urandom);
        ctrl_ula = 3'($urandom);
    endtask

    task automatic wait_valid(input string name, input int exp_edges);
        int k = 0;
        bit rdy_seen = 1'b0;
        while (!out_valid && k < 64) begin
            rdy_seen |= in_ready;
            @(posedge clk); #1;
            k++;
        end
        check({name, "_latency"}, k, exp_edges);
        check({name, "_busy_ready"}, rdy_seen, 0);
    endtask

    task automatic consume(input string name, input int hold, input logic [7:0] r);
        repeat (hold) begin
            @(posedge clk); #1;
            check({name, "_hold_out"}, out, r);
            check({name, "_hold_valid"}, out_valid, 1);
            check({name, "_hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_idle_ready"}, in_ready, 1);
        check({name, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; inA = '0; inB = '0; ctrl_ula = '0;
        v16_in_valid = 1'b0; v16_out_ready = 1'b0; v16_a = '0; v16_b = '0; v16_op = '0;

        vecs = '{
            '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0, 0},
            '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0, 0},
            '{3'd4, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, 0, 0},
            '{3'd7, 8'h55, 8'h66, 8'h00, 1'b0, 1'b0, 0, 0},
            '{3'd2, 8'h81, 8'h09, 8'h00, 1'b0, 1'b0, 0, 0},
            '{3'd2, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 0, 1},
            '{3'd6, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 0, 0},
            '{3'd6, 8'h80, 8'hC8, 8'hFF, 1'b0, 1'b0, 0, 0},
            '{3'd3, 8'hF0, 8'h04, 8'h0F, 1'b0, 1'b0, 0, 0},
            '{3'd3, 8'hF0, 8'h08, 8'h00, 1'b0, 1'b0, 0, 0},
            '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 0},
            '{3'd4, 8'h05, 8'h03, 8'h00, 1'b0, 1'b0, 0, 0},
            '{3'd5, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 8, 2},
            '{3'd5, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 8, 0},
            '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0, 5}
        };

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 8'h00);
        check("rst_zero", zero, 1);
        check("rst_carry", carry, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(nm, vecs[i].edges);
            check({nm, "_out"}, out, vecs[i].r);
            check({nm, "_carry"}, carry, vecs[i].c);
            check({nm, "_ovf"}, ovf, vecs[i].o);
            check({nm, "_zero"}, zero, vecs[i].r == 8'h00);
            consume(nm, vecs[i].hold, vecs[i].r);
        end

        // Put a nonzero result on out, then reset in the middle of a multiply.
        issue(3'd1, 8'h03, 8'h05);
        consume("pre_rst", 0, 8'hFE);
        issue(3'd5, 8'h10, 8'h11);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midmul_rst_out", out, 8'h00);
        check("midmul_rst_zero", zero, 1);
        check("midmul_rst_carry", carry, 0);
        check("midmul_rst_valid", out_valid, 0);
        check("midmul_rst_ready", in_ready, 1);
        #2 rst_n = 1'b1;
        k = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) k++;
        end
        check("post_rst_no_valid", k, 0);
        issue(3'd0, 8'h02, 8'h02);
        wait_valid("post_rst_add", 0);
        check("post_rst_add_out", out, 8'h04);
        consume("post_rst_add", 0, 8'h04);

        // 16-bit multiply latency and result.
        check("w16_ready", v16_in_ready, 1);
        v16_op = 3'd5; v16_a = 16'd300; v16_b = 16'd200; v16_in_valid = 1'b1;
        @(posedge clk); #1;
        v16_in_valid = 1'b0; v16_a = 16'hFFFF; v16_b = 16'hFFFF;
        k = 0;
        while (!v16_out_valid && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        check("w16_latency", k, 16);
        check("w16_out", v16_out, 16'hEA60);
        check("w16_carry", v16_carry, 0);
        check("w16_zero", v16_zero, 0);
        v16_out_ready = 1'b1;
        @(posedge clk); #1;
        v16_out_ready = 1'b0;
        check("w16_idle_ready", v16_in_ready, 1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
